// File: rtl/decode_stage_pipe.sv
// Registered ID stage: decodes one instruction into an ID/EX entry with valid/ready
// handshakes, a per-register load-use scoreboard, branch flush and illegal-type pulse.
module decode_stage_pipe #(
  parameter int  NUM_REGS = 32,
  parameter int  LD_LAT   = 2,
  parameter int  INST_W   = 32,
  localparam int RAW      = $clog2(NUM_REGS),
  localparam int CW       = $clog2(LD_LAT + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  input  logic [0:INST_W-1] if_inst,
  output logic            id_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [0:RAW-1]  ID_rD,
  output logic [0:RAW-1]  ID_rA,
  output logic [0:RAW-1]  ID_rB,
  output logic [0:2]      ID_ppp,
  output logic [0:1]      ID_WW,
  output logic [0:15]     ID_imm,
  output logic            ID_wrEn,
  output logic            ID_memEn,
  output logic            ID_memwrEn,
  output logic            ID_bez,
  output logic            ID_bnez,
  output logic            ID_ldwb,
  output logic            ID_illegal
);

  localparam logic [0:5] OP_RTYPE = 6'b101010;
  localparam logic [0:5] OP_VLD   = 6'b100000;
  localparam logic [0:5] OP_VSD   = 6'b100001;
  localparam logic [0:5] OP_VBEZ  = 6'b100010;
  localparam logic [0:5] OP_VBNEZ = 6'b100011;
  localparam logic [0:5] OP_VNOP  = 6'b111100;

  logic [0:5]     typ_w;
  logic [0:RAW-1] rd_w, ra_w, rb_w;
  logic           ra_zero_w;
  logic           wr_w, mem_w, memwr_w, bez_w, bnez_w, ldwb_w, ill_w;
  logic           src_a_w, src_b_w, src_d_w;

  assign typ_w     = if_inst[0:5];
  assign rd_w      = if_inst[6 +: RAW];
  assign ra_w      = if_inst[11 +: RAW];
  assign rb_w      = if_inst[16 +: RAW];
  assign ra_zero_w = (ra_w == '0);

  always_comb begin
    wr_w    = 1'b0;
    mem_w   = 1'b0;
    memwr_w = 1'b0;
    bez_w   = 1'b0;
    bnez_w  = 1'b0;
    ldwb_w  = 1'b0;
    ill_w   = 1'b0;
    src_a_w = 1'b0;
    src_b_w = 1'b0;
    src_d_w = 1'b0;
    case (typ_w)
      OP_RTYPE: begin wr_w = 1'b1; src_a_w = 1'b1; src_b_w = 1'b1; end
      OP_VLD:   begin mem_w = ra_zero_w; ldwb_w = ra_zero_w; end
      OP_VSD:   begin mem_w = ra_zero_w; memwr_w = ra_zero_w; src_d_w = 1'b1; end
      OP_VBEZ:  begin bez_w = ra_zero_w; src_d_w = 1'b1; end
      OP_VBNEZ: begin bnez_w = ra_zero_w; src_d_w = 1'b1; end
      OP_VNOP:  ;
      default:  ill_w = 1'b1;
    endcase
  end

  // ID/EX entry registers
  logic           valid_q, valid_d;
  logic [0:RAW-1] rd_q, ra_q, rb_q;
  logic [0:2]     ppp_q;
  logic [0:1]     ww_q;
  logic [0:15]    imm_q;
  logic           wr_q, mem_q, memwr_q, bez_q, bnez_q, ldwb_q, ill_q;

  logic [CW-1:0]     cnt_q [NUM_REGS];
  logic [CW-1:0]     cnt_d [NUM_REGS];
  logic [NUM_REGS-1:0] busy_w;
  logic              hazard_w, ex_hs_w, cap_w, ld_set_w;

  // A register is busy while its load-use counter runs or while a load to it sits in ID
  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    assign busy_w[gi] = (cnt_q[gi] != '0) || (valid_q && ldwb_q && (rd_q == RAW'(gi)));
    assign cnt_d[gi]  = (ld_set_w && (rd_q == RAW'(gi))) ? CW'(LD_LAT) :
                        (cnt_q[gi] != '0) ? cnt_q[gi] - 1'b1 : cnt_q[gi];
  end

  assign hazard_w = (src_a_w && (ra_w != '0) && busy_w[ra_w]) ||
                    (src_b_w && (rb_w != '0) && busy_w[rb_w]) ||
                    (src_d_w && (rd_w != '0) && busy_w[rd_w]);

  assign id_ready = (!valid_q || ex_ready) && !hazard_w;
  assign id_valid = valid_q && !flush;
  assign ex_hs_w  = id_valid && ex_ready;
  assign cap_w    = if_valid && id_ready && !flush;
  assign ld_set_w = ex_hs_w && ldwb_q && (rd_q != '0);

  always_comb begin
    valid_d = valid_q;
    if (flush)        valid_d = 1'b0;
    else if (cap_w)   valid_d = 1'b1;
    else if (ex_hs_w) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      rd_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      ppp_q   <= '0;
      ww_q    <= '0;
      imm_q   <= '0;
      wr_q    <= 1'b0;
      mem_q   <= 1'b0;
      memwr_q <= 1'b0;
      bez_q   <= 1'b0;
      bnez_q  <= 1'b0;
      ldwb_q  <= 1'b0;
      ill_q   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      ill_q   <= cap_w && ill_w;
      cnt_q   <= cnt_d;
      if (cap_w) begin
        rd_q    <= rd_w;
        ra_q    <= ra_w;
        rb_q    <= rb_w;
        ppp_q   <= if_inst[21:23];
        ww_q    <= if_inst[24:25];
        imm_q   <= if_inst[16:31];
        wr_q    <= wr_w;
        mem_q   <= mem_w;
        memwr_q <= memwr_w;
        bez_q   <= bez_w;
        bnez_q  <= bnez_w;
        ldwb_q  <= ldwb_w;
      end
    end
  end

  assign ID_rD      = rd_q;
  assign ID_rA      = ra_q;
  assign ID_rB      = rb_q;
  assign ID_ppp     = ppp_q;
  assign ID_WW      = ww_q;
  assign ID_imm     = imm_q;
  assign ID_wrEn    = wr_q;
  assign ID_memEn   = mem_q;
  assign ID_memwrEn = memwr_q;
  assign ID_bez     = bez_q;
  assign ID_bnez    = bnez_q;
  assign ID_ldwb    = ldwb_q;
  assign ID_illegal = ill_q;

endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Registered, stall-aware instruction decode stage for the vector CPU, between fetch (IF) and execute (EX).
- Decodes the 32-bit instruction word (type field, rD/rA/rB, ppp, WW, imm) into control strobes and holds them in one ID/EX pipeline entry with valid/ready handshakes.
- Adds a parametrised load-use scoreboard, branch flush and illegal-opcode reporting.
- Decodes VBEZ and VBNEZ as distinct types.

Parameters:
- NUM_REGS, 32, architectural registers; register address width RAW = clog2(NUM_REGS), 5 at default.
- LD_LAT, 2, cycles after a load leaves ID before its rD may be read by a following instruction; 1..15.
- INST_W, 32, instruction width; fields below assume 32.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_valid  in  1  if_inst valid.
- if_inst  in  [0:INST_W-1]  instruction, bit 0 = MSB.
- id_ready  out  1  ID accepts if_inst this cycle.
- flush  in  1  kill ID entry (taken branch in EX).
- ex_ready  in  1  EX accepts ID entry.
- id_valid  out  1  ID entry valid.
- ID_rD, ID_rA, ID_rB  out  [0:RAW-1] each  register fields.
- ID_ppp  out  [0:2]  participation field.
- ID_WW  out  [0:1]  element width.
- ID_imm  out  [0:15]  immediate/address.
- ID_wrEn, ID_memEn, ID_memwrEn, ID_bez, ID_bnez  out  1 each  control strobes.
- ID_ldwb  out  1  load result writes rD.
- ID_illegal  out  1  one-cycle pulse; unknown type accepted.

Behaviour:
- Fields: type = inst[0:5], rD = [6:10], rA = [11:15], rB = [16:20], ppp = [21:23], WW = [24:25], imm = [16:31].
- Type codes: RTYPE 101010, VLD 100000, VSD 100001, VBEZ 100010, VBNEZ 100011, VNOP 111100.
- RTYPE: wrEn = 1.
- VLD: memEn = ldwb = (rA == 0).
- VSD: memEn = memwrEn = (rA == 0).
- VBEZ: bez = (rA == 0). VBNEZ: bnez = (rA == 0).
- VNOP: all strobes 0.
- Any other type: all strobes 0 and ID_illegal pulses for the cycle after capture.
- Sources read by the incoming instruction:
  - RTYPE reads rA and rB.
  - VSD, VBEZ and VBNEZ read rD.
  - VLD, VNOP and illegal types read nothing.
- Hazard exists if any source register r != 0 is busy.
- r is busy if its counter is nonzero, or if the ID entry is valid with ldwb = 1 and ID_rD == r.
- id_ready = (!valid_q || ex_ready) && !hazard. This is combinational and independent of flush.
- id_valid = valid_q && !flush.
- Handshake: the EX handshake fires when id_valid && ex_ready. The capture handshake fires when if_valid && id_ready.
- Capture loads all output registers in one cycle; latency IF to ID is 1 cycle.
- On an EX handshake with no capture, valid_q clears.
- Outputs are held stable while id_valid && !ex_ready.
- Scoreboard: one counter per register, width clog2(LD_LAT+1).
  - On an EX handshake with ldwb = 1 and rD != 0, counter[rD] loads LD_LAT.
  - All other nonzero counters decrement by 1 per cycle.
  - A load to rD = 0 never marks busy.
- Flush:
  - valid_q clears next edge.
  - A capture in the same cycle is discarded; upstream is redirected.
  - No EX handshake occurs, so a killed load sets no counter.
  - In-flight counters are unaffected.
- Simultaneous EX handshake and capture: the entry is replaced in the same edge (back-to-back, no bubble).
- Reset asserted (including mid-operation): immediately clears valid_q, all counters, every strobe, ID_illegal and all fields to 0.
- Reset deasserted: the first capture occurs on the first edge with a capture handshake.

Test Plan:
- Reset, then RTYPE rD=3 rA=1 rB=2 ppp=000 WW=10, ex_ready=1 -> next cycle id_valid=1, ID_wrEn=1, ID_rD=3, ID_WW=2'b10, other strobes 0.
- VLD rD=5 rA=0, then RTYPE reading rA=5, LD_LAT=2, ex_ready=1:
  - id_ready=0 while the VLD sits in ID and for the 2 counter cycles.
  - The RTYPE is captured on the 3rd cycle after the VLD handshake.
  - A VLD rD=0 followed by the same RTYPE -> no stall.
- ex_ready=0 for 4 cycles with a VSD rA=0 held in ID -> outputs stable, id_ready=0; ex_ready=1 -> the handshake and the next capture occur on the same edge.
- VBNEZ rA=0 -> ID_bnez=1, ID_bez=0; VBEZ rA=0 -> ID_bez=1, ID_bnez=0; either with rA=7 -> both 0.
- VLD rD=4 in ID with flush=1, ex_ready=1 -> id_valid=0 that cycle, entry killed, no counter set; a following RTYPE reading r4 captures without stall.
- type 000111 accepted -> all strobes 0, ID_illegal=1 for exactly 1 cycle. rst_n low mid-stall with counters nonzero -> all outputs 0 asynchronously, counters 0.
